// File: rtl/md_pkg.sv
// md_pkg: shared MDOp codes, default latencies and op classification for md_unit
package md_pkg;
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_e;
   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;
   function automatic logic is_md(input logic [3:0] op);
`ifdef MD_MADD_EN
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
   endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit mult/div (and, with MD_MADD_EN, accumulate) result for md_unit
module md_arith
   import md_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
`ifdef MD_MADD_EN
   input  logic [31:0] hi,
   input  logic [31:0] lo,
`endif
   output logic [63:0] res
);
   logic [63:0] sp, up, prod;
   logic [31:0] bs, bu;
   logic signed [31:0] sq, sr;
   logic sgn, dz, ovf;
   always_comb begin
      sgn  = op == MD_MULT || op == MD_MADD || op == MD_MSUB;
      sp   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      up   = {32'b0, a} * {32'b0, b};
      prod = sgn ? sp : up;
      dz   = b == 32'h0;
      ovf  = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      // divisors forced to 1 in the special cases so the dividers never see /0 or overflow
      bs   = (dz || ovf) ? 32'd1 : b;
      bu   = dz ? 32'd1 : b;
      sq   = $signed(a) / $signed(bs);
      sr   = $signed(a) % $signed(bs);
      res  = (op == MD_DIV)  ? (dz ? {a, 32'hFFFF_FFFF} : ovf ? {32'h0, 32'h8000_0000} : {sr, sq})
           : (op == MD_DIVU) ? (dz ? {a, 32'hFFFF_FFFF} : {a % bu, a / bu})
`ifdef MD_MADD_EN
           : (op == MD_MADD || op == MD_MADDU) ? {hi, lo} + prod
           : (op == MD_MSUB || op == MD_MSUBU) ? {hi, lo} - prod
`endif
           : prod;
   end
endmodule

// File: rtl/md_unit.sv
// md_unit: multicycle HI/LO multiply/divide unit with decode stall; MD_MADD_EN enables madd/msub
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDOp,
   input  logic        Start,
   input  logic        HiLoSel,
   input  logic        isMD_D,
   output logic        Busy,
   output logic [31:0] HiLoOut,
   output logic        Stall_MD
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
   logic [31:0] hi, lo;
   logic [63:0] pend, res;
   logic [CW-1:0] cnt;
   logic acc, md, is_div;
   md_arith u_arith (
      .a(A),
      .b(B),
      .op(MDOp),
`ifdef MD_MADD_EN
      .hi(hi),
      .lo(lo),
`endif
      .res(res)
   );
   always_comb begin
      Busy     = |cnt;
      acc      = Start & ~Busy;
      md       = is_md(MDOp);
      is_div   = MDOp == MD_DIV || MDOp == MD_DIVU;
      HiLoOut  = HiLoSel ? hi : lo;
      Stall_MD = isMD_D & (Busy | (Start & md));
   end
   // result is captured at acceptance and only becomes visible when the count expires
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         pend <= '0;
         cnt  <= '0;
      end else if (acc && md) begin
         pend <= res;
         cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (acc && MDOp == MD_MTHI) begin
         hi <= A;
      end else if (acc && MDOp == MD_MTLO) begin
         lo <= A;
      end else if (Busy) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) {hi, lo} <= pend;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against a 64-bit arithmetic reference model
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;
   logic clk = 1'b0;
   logic reset, Start, HiLoSel, isMD_D, Busy, Stall_MD;
   logic [31:0] A, B, HiLoOut;
   logic [3:0] MDOp;
   logic [31:0] m_hi, m_lo;
   int total = 0;
   int bad = 0;

   md_unit dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
      .HiLoSel(HiLoSel), .isMD_D(isMD_D), .Busy(Busy), .HiLoOut(HiLoOut), .Stall_MD(Stall_MD)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_hilo(input string tag);
      HiLoSel = 1'b0;
      #1 check({tag, "_lo"}, 64'(HiLoOut), 64'(m_lo));
      HiLoSel = 1'b1;
      #1 check({tag, "_hi"}, 64'(HiLoOut), 64'(m_hi));
   endtask

   function automatic int lat(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return MC;
      if (op == 4'd3 || op == 4'd4) return DC;
`ifdef MD_MADD_EN
      if (op >= 4'd7 && op <= 4'd10) return MC;
`endif
      return 0;
   endfunction

   function automatic logic [63:0] ref_next(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] cur, sp, up;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      cur = {m_hi, m_lo};
      sp  = 64'(sa * sb);
      up  = {32'b0, a} * {32'b0, b};
      case (op)
         4'd1: return sp;
         4'd2: return up;
         4'd3: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         4'd5: return {a, m_lo};
         4'd6: return {m_hi, a};
`ifdef MD_MADD_EN
         4'd7:  return cur + sp;
         4'd8:  return cur + up;
         4'd9:  return cur - sp;
         4'd10: return cur - up;
`endif
         default: return cur;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] nxt;
      int n;
      nxt = ref_next(op, a, b);
      n   = lat(op);
      @(negedge clk);
      A = a; B = b; MDOp = op; Start = 1'b1; isMD_D = 1'b1;
      #1 check({tag, "_stall_accept"}, 64'(Stall_MD), 64'(n > 0));
      @(negedge clk);
      Start = 1'b0;
      for (int i = 0; i < n; i++) begin
         isMD_D  = 1'($urandom);
         HiLoSel = 1'($urandom);
         #1;
         check({tag, "_busy"}, 64'(Busy), 64'd1);
         check({tag, "_stall_busy"}, 64'(Stall_MD), 64'(isMD_D));
         check({tag, "_hold"}, 64'(HiLoOut), 64'(HiLoSel ? m_hi : m_lo));
         MDOp = 4'($urandom_range(1, 10)); A = $urandom; B = $urandom; Start = 1'b1;
         @(negedge clk);
      end
      Start = 1'b0;
      isMD_D = 1'b0;
      {m_hi, m_lo} = nxt;
      #1 check({tag, "_idle"}, 64'(Busy), 64'd0);
      check_hilo(tag);
   endtask

   initial begin
      reset = 1'b1; Start = 1'b0; A = '0; B = '0; MDOp = '0; HiLoSel = 1'b0; isMD_D = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      #1 check("rst_busy", 64'(Busy), 64'd0);
      check_hilo("rst");
      @(negedge clk);
      reset = 1'b0;
      run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
      run_op("divu", 4'd4, 32'd100, 32'd7);
      run_op("div0", 4'd3, 32'hFFFF_FFF9, 32'd0);
      run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divuovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mtlo", 4'd6, 32'd10, 32'd0);
      run_op("mthi", 4'd5, 32'd0, 32'd0);
      run_op("madd", 4'd7, 32'd3, 32'd4);
      run_op("msubu", 4'd10, 32'd2, 32'd5);
      run_op("unused", 4'd13, 32'h1234_5678, 32'd9);
      for (int k = 0; k < 40; k++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
         run_op("rand", 4'($urandom_range(0, 15)), ra, rb);
      end
      run_op("pre_rst_mthi", 4'd5, 32'hDEAD_BEEF, 32'd0);
      @(negedge clk);
      A = 32'd100; B = 32'd3; MDOp = 4'd3; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      m_hi = '0; m_lo = '0;
      #1 check("midrst_busy", 64'(Busy), 64'd0);
      check_hilo("midrst");
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 2) @(negedge clk);
      #1 check("postrst_busy", 64'(Busy), 64'd0);
      check_hilo("postrst");
      run_op("after_rst", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
